// File: rtl/vga_tile_renderer.sv
// Programmable-raster VGA timing generator with a two-stage tile renderer (3-3-2 RGB palette).
// Optional `VGA_GRID_LINES_EN draws grey grid lines on tile boundaries inside the board.
module vga_tile_renderer #(
    parameter int         H_ACTIVE  = 640,
    parameter int         H_FP      = 16,
    parameter int         H_SYNC    = 96,
    parameter int         H_BP      = 48,
    parameter int         V_ACTIVE  = 480,
    parameter int         V_FP      = 10,
    parameter int         V_SYNC    = 2,
    parameter int         V_BP      = 33,
    parameter bit         SYNC_POL  = 1'b0,
    parameter int         CLK_DIV   = 2,
    parameter int         TILE_LOG2 = 4,
    parameter int         BOARD_W   = 40,
    parameter int         BOARD_H   = 30,
    parameter int         X_OFF     = 0,
    parameter int         Y_OFF     = 0,
    parameter int         COORD_W   = 6,
    parameter int         DATA_W    = 3,
    parameter logic [7:0] BG_RGB    = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  board_data,
    output logic [2:0]         red,
    output logic [2:0]         green,
    output logic [1:0]         blue,
    output logic               hsync,
    output logic               vsync,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int TILE    = 1 << TILE_LOG2;

    function automatic logic [7:0] palette(input logic [DATA_W-1:0] code);
        case (32'(code))
            0:       palette = 8'h00;
            1:       palette = 8'h03;
            2:       palette = 8'hFF;
            3:       palette = 8'hFC;
            4:       palette = 8'hE0;
            5:       palette = 8'hF2;
            6:       palette = 8'h1F;
            7:       palette = 8'hF4;
            default: palette = BG_RGB;
        endcase
    endfunction

    logic [3:0]     div;
    logic           pix_tick;
    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_last, v_last;
    logic           visible, hs_act, vs_act, in_board;
    logic [31:0]    hx, vy;
    logic           vld_p1, in_board_p1, hs_p1, vs_p1;
    logic [7:0]     rgb_p2;

    assign pix_tick = (32'(div) == CLK_DIV - 1);
    assign h_last   = (32'(h_cnt) == H_TOTAL - 1);
    assign v_last   = (32'(v_cnt) == V_TOTAL - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            div <= pix_tick ? 4'd0 : div + 4'd1;
            if (pix_tick) begin
                h_cnt <= h_last ? '0 : h_cnt + 1'b1;
                if (h_last)
                    v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end
        end
    end

    // Offsets below the origin wrap to huge unsigned values, so one compare bounds both sides.
    assign hx       = 32'(h_cnt) - X_OFF;
    assign vy       = 32'(v_cnt) - Y_OFF;
    assign visible  = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign hs_act   = (32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_act   = (32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
    assign in_board = visible && (hx < BOARD_W * TILE) && (vy < BOARD_H * TILE);

`ifdef VGA_GRID_LINES_EN
    logic grid_p1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            grid_p1 <= 1'b0;
        else if (pix_tick)
            grid_p1 <= ((hx & (TILE - 1)) == 0) || ((vy & (TILE - 1)) == 0);
    end
`endif

    // Stage 1: tile address out to board memory, qualifiers delayed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            vld_p1      <= 1'b0;
            in_board_p1 <= 1'b0;
            hs_p1       <= 1'b0;
            vs_p1       <= 1'b0;
        end else if (pix_tick) begin
            x           <= in_board ? COORD_W'(hx >> TILE_LOG2) : '0;
            y           <= in_board ? COORD_W'(vy >> TILE_LOG2) : '0;
            vld_p1      <= visible;
            in_board_p1 <= in_board;
            hs_p1       <= hs_act;
            vs_p1       <= vs_act;
        end
    end

    // Stage 2: colour lookup on returned board_data, sync realigned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_p2 <= 8'h00;
            hsync  <= ~SYNC_POL;
            vsync  <= ~SYNC_POL;
        end else if (pix_tick) begin
            if (!vld_p1)
                rgb_p2 <= 8'h00;
            else if (!in_board_p1)
                rgb_p2 <= BG_RGB;
            else
`ifdef VGA_GRID_LINES_EN
                rgb_p2 <= grid_p1 ? 8'h49 : palette(board_data);
`else
                rgb_p2 <= palette(board_data);
`endif
            hsync <= hs_p1 ? SYNC_POL : ~SYNC_POL;
            vsync <= vs_p1 ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_start <= 1'b0;
        else
            frame_start <= pix_tick && h_last && v_last;
    end

    assign {red, green, blue} = rgb_p2;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Randomised bench for vga_tile_renderer on a reduced raster; reference derived from pixel-tick counting.
module tb_vga_tile_renderer;

    localparam int         HA = 40, HF = 4, HS = 6, HB = 6;
    localparam int         VA = 20, VF = 2, VS = 2, VB = 3;
    localparam int         HT = HA + HF + HS + HB;   // 56
    localparam int         VT = VA + VF + VS + VB;   // 27
    localparam int         N  = HT * VT;
    localparam int         CD = 2;
    localparam int         TL = 2;
    localparam int         T  = 1 << TL;
    localparam int         BW = 6, BH = 3, XO = 8, YO = 4;
    localparam int         CW = 6, DW = 4;
    localparam logic [7:0] BG = 8'h25;
    localparam bit         SP = 1'b0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] board_data = '0;
    logic [2:0]    red, green;
    logic [1:0]    blue;
    logic          hsync, vsync, frame_start;
    logic [CW-1:0] x, y;

    int nvec = 0;
    int nbad = 0;

    vga_tile_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(SP), .CLK_DIV(CD), .TILE_LOG2(TL),
        .BOARD_W(BW), .BOARD_H(BH), .X_OFF(XO), .Y_OFF(YO),
        .COORD_W(CW), .DATA_W(DW), .BG_RGB(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .board_data(board_data),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .x(x), .y(y), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] pal(input logic [DW-1:0] c);
        case (c)
            0: return 8'h00;  1: return 8'h03;  2: return 8'hFF;  3: return 8'hFC;
            4: return 8'hE0;  5: return 8'hF2;  6: return 8'h1F;  7: return 8'hF4;
            default: return BG;
        endcase
    endfunction

    function automatic bit on_board(input int h, input int v);
        return h < HA && v < VA && h >= XO && h < XO + BW * T && v >= YO && v < YO + BH * T;
    endfunction

    function automatic logic [7:0] pixel(input int h, input int v, input logic [DW-1:0] bd);
        if (h >= HA || v >= VA) return 8'h00;
        if (!on_board(h, v)) return BG;
`ifdef VGA_GRID_LINES_EN
        if ((h - XO) % T == 0 || (v - YO) % T == 0) return 8'h49;
`endif
        return pal(bd);
    endfunction

    // Reference: the raster position is simply the number of pixel ticks since reset, modulo N.
    int         e, k;
    logic [7:0] m_rgb;
    logic       m_hs, m_vs, m_fs;
    int         m_x, m_y;

    always @(posedge clk) begin
        int p, h, v;
        if (!rst_n) begin
            e = 0; k = 0; m_rgb = 0; m_hs = ~SP; m_vs = ~SP; m_fs = 0; m_x = 0; m_y = 0;
        end else begin
            e++;
            m_fs = 1'b0;
            if (e % CD == 0) begin
                k++;
                m_fs = (k % N == 0);
                p = (k - 1) % N; h = p % HT; v = p / HT;
                m_x = on_board(h, v) ? (h - XO) / T : 0;
                m_y = on_board(h, v) ? (v - YO) / T : 0;
                if (k >= 2) begin
                    p = (k - 2) % N; h = p % HT; v = p / HT;
                    m_rgb = pixel(h, v, board_data);
                    m_hs  = (h >= HA + HF && h < HA + HF + HS) ? SP : ~SP;
                    m_vs  = (v >= VA + VF && v < VA + VF + VS) ? SP : ~SP;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_rgb", {red, green, blue}, 0);
            check("rst_hsync", hsync, 1);
            check("rst_vsync", vsync, 1);
            check("rst_xy", {x, y}, 0);
            check("rst_frame_start", frame_start, 0);
        end else begin
            check("rgb", {red, green, blue}, m_rgb);
            check("hsync", hsync, m_hs);
            check("vsync", vsync, m_vs);
            check("x", x, m_x);
            check("y", y, m_y);
            check("frame_start", frame_start, m_fs);
        end
    end

    initial begin
        int f1, f2, hrun, vrun, hfall, fc_cnt, g_cnt, xmax, c;
        bit hprev;
        f1 = -1; f2 = -1; hrun = 0; vrun = 0; hfall = -1; fc_cnt = 0; g_cnt = 0; xmax = 0;
        hprev = 1'b1;

        repeat (20) @(negedge clk);
        #1 rst_n = 1'b1;
        board_data = 4'd3;

        // Constant code 3 for two frames: measure sync widths, periods and pixel counts.
        for (c = 1; c <= 2 * N * CD + 100; c++) begin
            @(negedge clk);
            if (frame_start) begin
                if (f1 < 0) f1 = c;
                else if (f2 < 0) f2 = c;
            end
            if (f1 > 0 && f2 < 0 && c > f1) begin
                if ({red, green, blue} == 8'hFC) fc_cnt++;
                if ({red, green, blue} == 8'h49) g_cnt++;
            end
            if (!hsync) hrun++;
            else if (hrun > 0) begin check("hsync_width", hrun, HS * CD); hrun = 0; end
            if (!vsync) vrun++;
            else if (vrun > 0) begin check("vsync_width", vrun, VS * HT * CD); vrun = 0; end
            if (hprev && !hsync) begin
                if (hfall >= 0) check("hsync_period", c - hfall, HT * CD);
                hfall = c;
            end
            hprev = hsync;
            if (int'(x) > xmax) xmax = int'(x);
        end
        check("first_frame_start", f1, N * CD);
        check("frame_period", f2 - f1, N * CD);
        check("x_max", xmax, BW - 1);
`ifdef VGA_GRID_LINES_EN
        check("code3_clks", fc_cnt, 18 * 9 * CD);
        check("grid_clks", g_cnt, (BW * T * BH * T - 18 * 9) * CD);
`else
        check("code3_clks", fc_cnt, BW * T * BH * T * CD);
        check("grid_clks", g_cnt, 0);
`endif

        // Random codes, including the >7 range that must render background.
        repeat (N * CD + 500) begin
            @(negedge clk);
            #1 board_data = DW'($urandom_range(0, (1 << DW) - 1));
        end

        // Reset mid-frame, then time the next frame_start from release.
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b1;
        f1 = -1;
        for (c = 1; c <= N * CD + 50; c++) begin
            @(negedge clk);
            if (frame_start && f1 < 0) f1 = c;
            #1 board_data = DW'($urandom_range(0, (1 << DW) - 1));
        end
        check("restart_frame_start", f1, N * CD);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
